multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
Main control state machine for the multicycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the datapath enables and mux selects, and supplies the 2-bit ALUop consumed by the ALU control unit (00 = add, 01 = subtract/compare, 10 = decode from funct fields). Its inputs are the latched IR opcode, the branch condition from the ALU, and a halt request from the register file.

Parameters:
MEM_LATENCY, 1, cycles a memory access occupies (legal range 1..15); applies to both instruction and data accesses.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset; low = in reset
opcode  input  7  IR[6:0] of the latched instruction
bcond  input  1  branch-taken flag from the ALU, valid in the EX state of a branch
halt_req  input  1  high when x17 == 10; sampled in ID for ECALL
pc_write  output  1  PC <= ALU result
old_pc_write  output  1  old_pc <= PC
ir_write  output  1  IR <= memory data
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
alu_src_a  output  2  ALU operand A: 00 = PC, 01 = old_pc, 10 = rs1 register A
alu_src_b  output  2  ALU operand B: 00 = rs2 register B, 01 = constant 4, 10 = immediate
ALUop  output  2  to the ALU control unit
reg_write  output  1  register file write enable
wb_sel  output  2  write data select: 00 = ALUOut, 01 = MDR, 10 = PC
is_halted  output  1  core halted

Behaviour:
- State register and wait counter (4 bits) are clocked on clk; outputs are combinational decodes of state, opcode and bcond.
- While reset is low: state = IF, counter = 0, and every output is forced to 0. After release, the first IF cycle starts on the next edge.
- Outputs not listed for a state are 0. ALUop defaults to 00.
- IF:
  - mem_read=1, i_or_d=0.
  - Counter increments each cycle. On the cycle where counter == MEM_LATENCY-1: ir_write=1, old_pc_write=1, pc_write=1, alu_src_a=00, alu_src_b=01, ALUop=00 (PC <= PC+4). Counter clears and the next state is ID.
- ID:
  - Register read; no enables.
  - Opcode 1110011 (ECALL): go to HALT if halt_req=1, otherwise go to IF.
  - Opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111: go to EX.
  - Any other opcode: go to IF (treated as a NOP).
- EX, by opcode:
  - R-type: ALUop=10, alu_src_a=10, alu_src_b=00; next state WB.
  - I-arith: ALUop=10, alu_src_a=10, alu_src_b=10; next state WB.
  - LOAD/STORE: ALUop=00, alu_src_a=10, alu_src_b=10; next state MEM.
  - BRANCH: ALUop=01, alu_src_a=10, alu_src_b=00. Next state BR if bcond=1, else IF (PC already holds PC+4).
  - JAL: ALUop=00, alu_src_a=01, alu_src_b=10, pc_write=1, reg_write=1, wb_sel=10 (rd <= PC+4); next state IF.
  - JALR: same as JAL except alu_src_a=10.
- BR: alu_src_a=01, alu_src_b=10, ALUop=00, pc_write=1; next state IF.
- MEM:
  - i_or_d=1; mem_read=1 for a load, mem_write=1 for a store. Strobes stay high for MEM_LATENCY cycles, using the same counter rule as IF.
  - On the last cycle, a load goes to WB and a store goes to IF.
- WB: reg_write=1; wb_sel=01 for a load, 00 otherwise; next state IF.
- HALT: is_halted=1, all other outputs 0. Absorbing; only reset exits.
- opcode is sampled combinationally every cycle. IR is stable from ID until the next IF completes, so the decode cannot change mid-instruction.
- Reset asserted in any state, including mid-MEM with strobes high, aborts immediately: strobes drop asynchronously and the counter clears.

Optional Feature:
MC_PERF_COUNT_EN
- Defined: adds outputs cycle_count[31:0] and instret[31:0], both reset to 0.
  - cycle_count increments every cycle not in HALT.
  - instret increments on each transition into IF from ID, EX, BR, MEM or WB, and on entry to HALT.
  - Both counters wrap modulo 2^32.
- Not defined: neither port exists and the counter logic is not built.

Test Plan:
- MEM_LATENCY=1, add (opcode 0110011): states IF,ID,EX,WB = 4 cycles. ALUop is 00 in IF and 10 in EX. reg_write=1 with wb_sel=00 only in WB.
- Branch with bcond=1 in EX: IF,ID,EX,BR. ALUop is 01 in EX and 00 in BR. pc_write pulses in IF and BR. With bcond=0 the sequence ends after EX (3 cycles).
- MEM_LATENCY=3, load (0000011): 3 IF + ID + EX + 3 MEM + WB = 9 cycles. mem_read is high 3 cycles in IF and 3 in MEM. i_or_d=1 only in MEM. wb_sel=01 in WB.
- JAL (1101111): in EX, pc_write=1, reg_write=1, wb_sel=10, alu_src_a=01 all in the same cycle; next state IF.
- ECALL with halt_req=1: HALT reached after ID. is_halted stays 1 for 20 further cycles with all strobes 0. Pulsing reset low returns to IF.
- Store with MEM_LATENCY=3, reset driven low in the 2nd MEM cycle: mem_write drops in the same cycle. After release, IF runs with counter 0. With MC_PERF_COUNT_EN defined, the counters read 0 after release.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control state machine of the multicycle RV32I core. Each instruction
// is walked through IF -> ID -> EX -> (MEM) -> (WB | BR), with HALT as an
// absorbing state entered by ECALL when halt_req is set. All datapath
// enables and mux selects are combinational decodes of the current state,
// the latched opcode and bcond.
//
// Parameters:
//   MEM_LATENCY  cycles one memory access occupies (1..15); used for both
//                the instruction fetch and the data access.
//
// Ports:
//   clk           core clock, rising edge
//   reset         asynchronous active-low reset (low = in reset)
//   opcode        IR[6:0] of the latched instruction
//   bcond         branch-taken flag from the ALU (valid in EX of a branch)
//   halt_req      x17 == 10, sampled in ID for ECALL
//   pc_write      PC <= ALU result
//   old_pc_write  old_pc <= PC
//   ir_write      IR <= memory data
//   i_or_d        memory address select: 0 = PC, 1 = ALUOut
//   mem_read      memory read strobe
//   mem_write     memory write strobe
//   alu_src_a     00 = PC, 01 = old_pc, 10 = register A
//   alu_src_b     00 = register B, 01 = constant 4, 10 = immediate
//   ALUop         00 = add, 01 = subtract/compare, 10 = decode funct
//   reg_write     register file write enable
//   wb_sel        00 = ALUOut, 01 = MDR, 10 = PC
//   is_halted     core halted
//   cycle_count   (MC_PERF_COUNT_EN only) cycles spent outside HALT
//   instret       (MC_PERF_COUNT_EN only) retired instructions
//
// Optional feature macro: MC_PERF_COUNT_EN adds the two performance counters.
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        bcond,
  input  logic        halt_req,
  output logic        pc_write,
  output logic        old_pc_write,
  output logic        ir_write,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  ALUop,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
`ifdef MC_PERF_COUNT_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instret,
`endif
  output logic        is_halted
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;

  // Value of the wait counter on the final cycle of a memory access.
  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_BR   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       mem_last;

  assign mem_last = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    pc_write     = 1'b0;
    old_pc_write = 1'b0;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    ALUop        = 2'b00;
    reg_write    = 1'b0;
    wb_sel       = 2'b00;
    is_halted    = 1'b0;

    case (state)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_last) begin
          // Fetch completes: latch IR, save old PC, advance PC by 4.
          ir_write     = 1'b1;
          old_pc_write = 1'b1;
          pc_write     = 1'b1;
          alu_src_b    = 2'b01;
          cnt_next     = 4'd0;
          state_next   = S_ID;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      S_ID: begin
        case (opcode)
          OP_ECALL: state_next = halt_req ? S_HALT : S_IF;
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR:
                    state_next = S_EX;
          default:  state_next = S_IF;
        endcase
      end

      S_EX: begin
        state_next = S_IF;
        case (opcode)
          OP_R: begin
            ALUop      = 2'b10;
            alu_src_a  = 2'b10;
            state_next = S_WB;
          end
          OP_I: begin
            ALUop      = 2'b10;
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b10;
            state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 2'b10;
            alu_src_b  = 2'b10;
            state_next = S_MEM;
          end
          OP_BR: begin
            // Not taken falls back to IF: PC already holds PC+4.
            ALUop      = 2'b01;
            alu_src_a  = 2'b10;
            state_next = bcond ? S_BR : S_IF;
          end
          OP_JAL, OP_JALR: begin
            alu_src_a = (opcode == OP_JAL) ? 2'b01 : 2'b10;
            alu_src_b = 2'b10;
            pc_write  = 1'b1;
            reg_write = 1'b1;
            wb_sel    = 2'b10;
          end
          default: state_next = S_IF;
        endcase
      end

      S_BR: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_write   = 1'b1;
        state_next = S_IF;
      end

      S_MEM: begin
        i_or_d = 1'b1;
        if (opcode == OP_LOAD) mem_read  = 1'b1;
        else                   mem_write = 1'b1;
        if (mem_last) begin
          cnt_next   = 4'd0;
          state_next = (opcode == OP_LOAD) ? S_WB : S_IF;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        state_next = S_IF;
      end

      S_HALT: begin
        is_halted = 1'b1;
      end

      default: state_next = S_IF;
    endcase

    // Reset masks every output immediately, so strobes drop the moment
    // reset goes low rather than at the next clock edge.
    if (!reset) begin
      pc_write     = 1'b0;
      old_pc_write = 1'b0;
      ir_write     = 1'b0;
      i_or_d       = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      alu_src_a    = 2'b00;
      alu_src_b    = 2'b00;
      ALUop        = 2'b00;
      reg_write    = 1'b0;
      wb_sel       = 2'b00;
      is_halted    = 1'b0;
    end
  end

`ifdef MC_PERF_COUNT_EN
  logic retire;

  // An instruction retires when control returns to IF from any other
  // state (IF->IF is just fetch wait), or when ECALL enters HALT.
  assign retire = ((state_next == S_IF)   && (state != S_IF)) ||
                  ((state_next == S_HALT) && (state != S_HALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= 32'd0;
      instret     <= 32'd0;
    end else begin
      if (state != S_HALT) cycle_count <= cycle_count + 32'd1;
      if (retire)          instret     <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  // Expected output vectors, packed MSB first as:
  // pc_write, old_pc_write, ir_write, i_or_d, mem_read, mem_write,
  // alu_src_a[1:0], alu_src_b[1:0], ALUop[1:0], reg_write, wb_sel[1:0], is_halted
  localparam logic [15:0] E_ZERO    = 16'h0000;
  localparam logic [15:0] E_IF_WAIT = 16'h0800;
  localparam logic [15:0] E_IF_LAST = 16'hE840;
  localparam logic [15:0] E_ID      = 16'h0000;
  localparam logic [15:0] E_EX_R    = 16'h0220;
  localparam logic [15:0] E_EX_I    = 16'h02A0;
  localparam logic [15:0] E_EX_LS   = 16'h0280;
  localparam logic [15:0] E_EX_BR   = 16'h0210;
  localparam logic [15:0] E_EX_JAL  = 16'h818C;
  localparam logic [15:0] E_EX_JALR = 16'h828C;
  localparam logic [15:0] E_BR      = 16'h8180;
  localparam logic [15:0] E_MEM_LD  = 16'h1800;
  localparam logic [15:0] E_MEM_ST  = 16'h1400;
  localparam logic [15:0] E_WB_LD   = 16'h000A;
  localparam logic [15:0] E_WB_ALU  = 16'h0008;
  localparam logic [15:0] E_HALT    = 16'h0001;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_ECALL = 7'b1110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic       bcond = 1'b0;
  logic       halt_req = 1'b0;
  logic       sel = 1'b0;

  logic        pc_write_1, old_pc_write_1, ir_write_1, i_or_d_1, mem_read_1, mem_write_1;
  logic [1:0]  alu_src_a_1, alu_src_b_1, ALUop_1, wb_sel_1;
  logic        reg_write_1, is_halted_1;
  logic        pc_write_3, old_pc_write_3, ir_write_3, i_or_d_3, mem_read_3, mem_write_3;
  logic [1:0]  alu_src_a_3, alu_src_b_3, ALUop_3, wb_sel_3;
  logic        reg_write_3, is_halted_3;
`ifdef MC_PERF_COUNT_EN
  logic [31:0] cycle_count_1, instret_1, cycle_count_3, instret_3;
`endif

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
    .pc_write(pc_write_1), .old_pc_write(old_pc_write_1), .ir_write(ir_write_1),
    .i_or_d(i_or_d_1), .mem_read(mem_read_1), .mem_write(mem_write_1),
    .alu_src_a(alu_src_a_1), .alu_src_b(alu_src_b_1), .ALUop(ALUop_1),
    .reg_write(reg_write_1), .wb_sel(wb_sel_1),
`ifdef MC_PERF_COUNT_EN
    .cycle_count(cycle_count_1), .instret(instret_1),
`endif
    .is_halted(is_halted_1)
  );

  multicycle_control_fsm #(.MEM_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
    .pc_write(pc_write_3), .old_pc_write(old_pc_write_3), .ir_write(ir_write_3),
    .i_or_d(i_or_d_3), .mem_read(mem_read_3), .mem_write(mem_write_3),
    .alu_src_a(alu_src_a_3), .alu_src_b(alu_src_b_3), .ALUop(ALUop_3),
    .reg_write(reg_write_3), .wb_sel(wb_sel_3),
`ifdef MC_PERF_COUNT_EN
    .cycle_count(cycle_count_3), .instret(instret_3),
`endif
    .is_halted(is_halted_3)
  );

  logic [15:0] act_1, act_3, act;
  assign act_1 = {pc_write_1, old_pc_write_1, ir_write_1, i_or_d_1, mem_read_1, mem_write_1,
                  alu_src_a_1, alu_src_b_1, ALUop_1, reg_write_1, wb_sel_1, is_halted_1};
  assign act_3 = {pc_write_3, old_pc_write_3, ir_write_3, i_or_d_3, mem_read_3, mem_write_3,
                  alu_src_a_3, alu_src_b_3, ALUop_3, reg_write_3, wb_sel_3, is_halted_3};
  assign act = sel ? act_3 : act_1;

  typedef struct {
    string       name;
    logic [15:0] vec;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  // One stimulus cycle: drive inputs just after the falling edge and queue
  // the output vector expected for that cycle.
  task automatic cyc(input string name, input logic [6:0] op, input logic b,
                     input logic h, input logic r, input logic [15:0] e);
    exp_t x;
    @(negedge clk);
    opcode   = op;
    bcond    = b;
    halt_req = h;
    reset    = r;
    x.name   = name;
    x.vec    = e;
    q.push_back(x);
  endtask

  // Deassert reset just after a rising edge so the next edge is the first
  // one the FSM acts on.
  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic fetch1(input logic [6:0] op);
    cyc("if", op, 1'b0, 1'b0, 1'b1, E_IF_LAST);
    cyc("id", op, 1'b0, 1'b0, 1'b1, E_ID);
  endtask

  task automatic fetch3(input logic [6:0] op);
    cyc("if_w0", op, 1'b0, 1'b0, 1'b1, E_IF_WAIT);
    cyc("if_w1", op, 1'b0, 1'b0, 1'b1, E_IF_WAIT);
    cyc("if",    op, 1'b0, 1'b0, 1'b1, E_IF_LAST);
    cyc("id",    op, 1'b0, 1'b0, 1'b1, E_ID);
  endtask

`ifdef MC_PERF_COUNT_EN
  task automatic check_cnt(input string name, input logic [31:0] ec, input logic [31:0] ei);
    logic [31:0] ac, ai;
    #2;
    ac = sel ? cycle_count_3 : cycle_count_1;
    ai = sel ? instret_3 : instret_1;
    checks++;
    if (ac !== ec) begin
      failures++;
      $display("FAIL %s cycle_count got=%0d exp=%0d", name, ac, ec);
    end
    checks++;
    if (ai !== ei) begin
      failures++;
      $display("FAIL %s instret got=%0d exp=%0d", name, ai, ei);
    end
  endtask
`endif

  // Monitor: every cycle the FSM presents its outputs; compare against the
  // oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (act !== x.vec) begin
          failures++;
          $display("FAIL %s (L%0d) got=%h exp=%h at %0t", x.name, sel ? 3 : 1, act, x.vec, $time);
        end
      end
    end
  end

  initial begin
    // ---------------- MEM_LATENCY = 1 ----------------
    sel = 1'b0;
    cyc("rst0", OP_R, 1'b0, 1'b0, 1'b0, E_ZERO);
    cyc("rst1", OP_R, 1'b0, 1'b0, 1'b0, E_ZERO);
    release_reset();

    fetch1(OP_R);
    cyc("ex_r", OP_R, 1'b0, 1'b0, 1'b1, E_EX_R);
    cyc("wb_r", OP_R, 1'b0, 1'b0, 1'b1, E_WB_ALU);

    fetch1(OP_I);
    cyc("ex_i", OP_I, 1'b0, 1'b0, 1'b1, E_EX_I);
    cyc("wb_i", OP_I, 1'b0, 1'b0, 1'b1, E_WB_ALU);

    fetch1(OP_BR);
    cyc("ex_bt", OP_BR, 1'b1, 1'b0, 1'b1, E_EX_BR);
    cyc("br",    OP_BR, 1'b0, 1'b0, 1'b1, E_BR);

    fetch1(OP_BR);
    cyc("ex_bn", OP_BR, 1'b0, 1'b0, 1'b1, E_EX_BR);

    fetch1(OP_JAL);
    cyc("ex_jal", OP_JAL, 1'b0, 1'b0, 1'b1, E_EX_JAL);

    fetch1(OP_JALR);
    cyc("ex_jalr", OP_JALR, 1'b0, 1'b0, 1'b1, E_EX_JALR);

    fetch1(OP_LUI);
    cyc("nop_if", OP_LUI, 1'b0, 1'b0, 1'b1, E_IF_LAST);
    cyc("nop_id", OP_LUI, 1'b0, 1'b0, 1'b1, E_ID);

    cyc("ecall0_if", OP_ECALL, 1'b0, 1'b0, 1'b1, E_IF_LAST);
    cyc("ecall0_id", OP_ECALL, 1'b0, 1'b0, 1'b1, E_ID);

    fetch1(OP_STORE);
    cyc("ex_st",  OP_STORE, 1'b0, 1'b0, 1'b1, E_EX_LS);
    cyc("mem_st", OP_STORE, 1'b0, 1'b0, 1'b1, E_MEM_ST);

    fetch1(OP_LOAD);
    cyc("ex_ld",  OP_LOAD, 1'b0, 1'b0, 1'b1, E_EX_LS);
    cyc("mem_ld", OP_LOAD, 1'b0, 1'b0, 1'b1, E_MEM_LD);
    cyc("wb_ld",  OP_LOAD, 1'b0, 1'b0, 1'b1, E_WB_LD);

    cyc("ecall1_if", OP_ECALL, 1'b0, 1'b1, 1'b1, E_IF_LAST);
    cyc("ecall1_id", OP_ECALL, 1'b0, 1'b1, 1'b1, E_ID);
    for (int i = 0; i < 21; i++)
      cyc("halt", (i % 2 == 0) ? OP_R : OP_LOAD, i[0], i[1], 1'b1, E_HALT);
    cyc("halt_rst", OP_R, 1'b0, 1'b0, 1'b0, E_ZERO);
    release_reset();
    fetch1(OP_R);
    cyc("ex_r2", OP_R, 1'b0, 1'b0, 1'b1, E_EX_R);
    cyc("wb_r2", OP_R, 1'b0, 1'b0, 1'b1, E_WB_ALU);

    // ---------------- MEM_LATENCY = 3 ----------------
    cyc("rst3", OP_LOAD, 1'b0, 1'b0, 1'b0, E_ZERO);
    sel = 1'b1;
    cyc("rst3b", OP_LOAD, 1'b0, 1'b0, 1'b0, E_ZERO);
    release_reset();
`ifdef MC_PERF_COUNT_EN
    check_cnt("cnt_after_rst", 32'd0, 32'd0);
`endif

    fetch3(OP_LOAD);
    cyc("ex_ld3",   OP_LOAD, 1'b0, 1'b0, 1'b1, E_EX_LS);
    cyc("mem_ld3a", OP_LOAD, 1'b0, 1'b0, 1'b1, E_MEM_LD);
    cyc("mem_ld3b", OP_LOAD, 1'b0, 1'b0, 1'b1, E_MEM_LD);
    cyc("mem_ld3c", OP_LOAD, 1'b0, 1'b0, 1'b1, E_MEM_LD);
    cyc("wb_ld3",   OP_LOAD, 1'b0, 1'b0, 1'b1, E_WB_LD);

    cyc("if_w0", OP_STORE, 1'b0, 1'b0, 1'b1, E_IF_WAIT);
`ifdef MC_PERF_COUNT_EN
    check_cnt("cnt_after_ld", 32'd9, 32'd1);
`endif
    cyc("if_w1", OP_STORE, 1'b0, 1'b0, 1'b1, E_IF_WAIT);
    cyc("if",    OP_STORE, 1'b0, 1'b0, 1'b1, E_IF_LAST);
    cyc("id",    OP_STORE, 1'b0, 1'b0, 1'b1, E_ID);
    cyc("ex_st3",   OP_STORE, 1'b0, 1'b0, 1'b1, E_EX_LS);
    cyc("mem_st3a", OP_STORE, 1'b0, 1'b0, 1'b1, E_MEM_ST);
    cyc("mem_st3_abort", OP_STORE, 1'b0, 1'b0, 1'b0, E_ZERO);
    cyc("abort_hold", OP_STORE, 1'b0, 1'b0, 1'b0, E_ZERO);
    release_reset();
`ifdef MC_PERF_COUNT_EN
    check_cnt("cnt_after_abort", 32'd0, 32'd0);
`endif
    fetch3(OP_R);
    cyc("ex_r3", OP_R, 1'b0, 1'b0, 1'b1, E_EX_R);
    cyc("wb_r3", OP_R, 1'b0, 1'b0, 1'b1, E_WB_ALU);

    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!(stim_done && q.size() == 0) && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    if (budget >= 2000) begin
      checks++;
      failures++;
      $display("FAIL timeout pending=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
